// File: rtl/sc_lane_shift_scheduler.sv
// sc_lane_shift_scheduler
// Background lane scheduler for the Frogger playfield. A shared prescaler
// produces a tick in RUN; each lane counts ticks against its own period and
// issues a one-clock shift code in its fixed direction. A falling edge on the
// movement button forces every enabled lane to shift at once. startGame low
// pauses everything with counters frozen. All outputs are registered one
// clock after the cycle in which the decision is made.
module sc_lane_shift_scheduler #(
  parameter int                 N_LANES   = 4,
  parameter int                 CNT_W     = 8,
  parameter int                 PRESC_MAX = 50000,
  parameter int                 PRESC_W   = 16,
  parameter logic [N_LANES-1:0] DIR_MASK  = 4'b0101
) (
  input  logic                       SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic                       SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic                       SC_STATEMACHINEBACKG_startGame_InLow,
  input  logic                       SC_STATEMACHINEBACKG_movement_InLow,
  input  logic [N_LANES*CNT_W-1:0]   lane_period_InBus,
  output logic [2*N_LANES-1:0]       shiftselection_OutBus,
  output logic                       upcount_OutLow,
  output logic                       running_Out
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_MAX - 1);

  localparam logic [1:0] SEL_HOLD  = 2'b11;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LOAD  = 2'b00;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [PRESC_W-1:0]   presc_r;
  logic [PRESC_W-1:0]   presc_nxt_s;
  logic [CNT_W-1:0]     cnt_r      [N_LANES];
  logic [CNT_W-1:0]     cnt_nxt_s  [N_LANES];
  logic [CNT_W-1:0]     period_s   [N_LANES];
  logic [N_LANES-1:0]   shift_s;
  logic                 mov_prev_r;
  logic                 run_en_s;
  logic                 tick_s;
  logic                 forced_s;
  logic [2*N_LANES-1:0] sel_nxt_s;
  logic [2*N_LANES-1:0] sel_r;
  logic                 upcount_r;
  logic                 running_r;

  // Next-state logic: LOAD lasts one clock, then startGame level picks RUN or PAUSE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RESET: state_nxt_s = ST_LOAD;
      ST_LOAD: begin
        if (SC_STATEMACHINEBACKG_startGame_InLow) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_RUN: begin
        if (SC_STATEMACHINEBACKG_startGame_InLow) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (SC_STATEMACHINEBACKG_startGame_InLow) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      default: state_nxt_s = ST_RESET;
    endcase
  end

  // Prescaler, tick/forced decisions, per-lane counters and shift codes.
  always_comb begin
    // A pause request arriving in RUN wins over a tick in the same clock.
    run_en_s    = (state_r == ST_RUN) && SC_STATEMACHINEBACKG_startGame_InLow;
    tick_s      = run_en_s && (presc_r == PRESC_LAST);
    forced_s    = run_en_s && mov_prev_r && !SC_STATEMACHINEBACKG_movement_InLow;
    presc_nxt_s = presc_r;
    shift_s     = '0;
    sel_nxt_s   = '1;
    if (tick_s) begin
      presc_nxt_s = '0;
    end else if (run_en_s) begin
      presc_nxt_s = presc_r + PRESC_W'(1);
    end else begin
      presc_nxt_s = presc_r;
    end
    for (int i = 0; i < N_LANES; i++) begin
      period_s[i]  = lane_period_InBus[i*CNT_W +: CNT_W];
      cnt_nxt_s[i] = cnt_r[i];
      if (period_s[i] == '0) begin
        // Frozen lane: counter pinned at zero, forced shifts ignored.
        cnt_nxt_s[i] = '0;
      end else if (forced_s) begin
        // A forced shift absorbs any coincident natural shift: one pulse only.
        cnt_nxt_s[i] = '0;
        shift_s[i]   = 1'b1;
      end else if (tick_s) begin
        // >= so that a period lowered below the current count wraps promptly.
        if (cnt_r[i] >= (period_s[i] - CNT_W'(1))) begin
          cnt_nxt_s[i] = '0;
          shift_s[i]   = 1'b1;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
      if (state_r == ST_LOAD) begin
        sel_nxt_s[2*i +: 2] = SEL_LOAD;
      end else if (shift_s[i]) begin
        if (DIR_MASK[i]) begin
          sel_nxt_s[2*i +: 2] = SEL_LEFT;
        end else begin
          sel_nxt_s[2*i +: 2] = SEL_RIGHT;
        end
      end else begin
        sel_nxt_s[2*i +: 2] = SEL_HOLD;
      end
    end
  end

  // State, counters, edge detector and registered outputs.
  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      state_r    <= ST_RESET;
      presc_r    <= '0;
      mov_prev_r <= 1'b1;
      sel_r      <= '1;
      upcount_r  <= 1'b1;
      running_r  <= 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      state_r    <= state_nxt_s;
      presc_r    <= presc_nxt_s;
      mov_prev_r <= SC_STATEMACHINEBACKG_movement_InLow;
      sel_r      <= sel_nxt_s;
      upcount_r  <= !tick_s;
      running_r  <= run_en_s;
      for (int i = 0; i < N_LANES; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign shiftselection_OutBus = sel_r;
  assign upcount_OutLow        = upcount_r;
  assign running_Out           = running_r;

endmodule

// File: tb/tb_sc_lane_shift_scheduler.sv
// Testbench for sc_lane_shift_scheduler: a hand-written vector table for the
// startup sequence, directed multi-cycle sequences, and randomized stimulus
// checked against a behavioural model of the scheduling rules.
module tb_sc_lane_shift_scheduler;

  localparam int         NL   = 4;
  localparam int         CW   = 8;
  localparam int         PM   = 4;
  localparam logic [3:0] DIRM = 4'b0101;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b1;
  logic          mov = 1'b1;
  logic [31:0]   periods = 32'h0;
  logic [7:0]    sel;
  logic          up;
  logic          run;

  int checks = 0;
  int errors = 0;

  // model state
  int          m_mode;      // 0 reset, 1 load, 2 run, 3 pause
  int          m_p;
  int          m_cnt [NL];
  logic        m_prev;
  logic [7:0]  e_sel;
  logic        e_up;
  logic        e_run;

  typedef struct {
    logic       start;
    logic       mov;
    logic [7:0] sel;
    logic       up;
    logic       run;
  } vec_t;

  vec_t tbl [26];

  sc_lane_shift_scheduler #(
    .N_LANES(NL), .CNT_W(CW), .PRESC_MAX(PM), .PRESC_W(16), .DIR_MASK(DIRM)
  ) dut (
    .SC_STATEMACHINEBACKG_CLOCK_50(clk),
    .SC_STATEMACHINEBACKG_RESET_InHigh(rst),
    .SC_STATEMACHINEBACKG_startGame_InLow(start),
    .SC_STATEMACHINEBACKG_movement_InLow(mov),
    .lane_period_InBus(periods),
    .shiftselection_OutBus(sel),
    .upcount_OutLow(up),
    .running_Out(run)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0;
    m_p    = 0;
    for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    m_prev = 1'b1;
    e_sel  = 8'hFF;
    e_up   = 1'b1;
    e_run  = 1'b0;
  endfunction

  // One clock of the game rules, applied to the inputs seen at this edge.
  function automatic void model_step();
    logic active;
    logic fall;
    logic tick;
    logic forced;
    active = (m_mode == 2) && start;
    fall   = m_prev && !mov;
    tick   = active && (m_p == PM - 1);
    forced = active && fall;
    for (int i = 0; i < NL; i++) begin
      int   per;
      logic sh;
      per = int'(periods[i*CW +: CW]);
      sh  = 1'b0;
      if (per == 0) begin
        m_cnt[i] = 0;
      end else if (forced) begin
        sh = 1'b1;
        m_cnt[i] = 0;
      end else if (tick) begin
        if (m_cnt[i] >= per - 1) begin
          sh = 1'b1;
          m_cnt[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (m_mode == 1)      e_sel[2*i +: 2] = 2'b00;
      else if (sh && DIRM[i]) e_sel[2*i +: 2] = 2'b10;
      else if (sh)          e_sel[2*i +: 2] = 2'b01;
      else                  e_sel[2*i +: 2] = 2'b11;
    end
    e_up  = !tick;
    e_run = active;
    if (active) m_p = (m_p + 1) % PM;
    m_prev = mov;
    if (m_mode == 0) m_mode = 1;
    else m_mode = start ? 2 : 3;
  endfunction

  task automatic step_chk(input string nm);
    @(posedge clk);
    model_step();
    #1;
    chk({nm, "_sel"}, 32'(sel), 32'(e_sel));
    chk({nm, "_up"},  32'(up),  32'(e_up));
    chk({nm, "_run"}, 32'(run), 32'(e_run));
  endtask

  // Step until the next edge will be a prescaler tick in RUN.
  task automatic align_tick(input string nm);
    for (int k = 0; k < 12 && !(m_mode == 2 && m_p == PM - 1); k++) step_chk(nm);
    checks++;
    if (!(m_mode == 2 && m_p == PM - 1)) begin
      errors++;
      $display("FAIL %s_align actual=p%0d required=p%0d", nm, m_p, PM - 1);
    end
  endtask

  initial begin
    // startup table, periods {lane3..lane0} = {0,3,2,1}
    for (int k = 0; k < 26; k++) tbl[k] = '{start:1'b1, mov:1'b1, sel:8'hFF, up:1'b1, run:1'b1};
    tbl[0].run = 1'b0;
    tbl[1].sel = 8'h00; tbl[1].run = 1'b0;
    tbl[5].sel  = 8'hFE; tbl[5].up  = 1'b0;
    tbl[9].sel  = 8'hF6; tbl[9].up  = 1'b0;
    tbl[13].sel = 8'hEE; tbl[13].up = 1'b0;
    tbl[17].sel = 8'hF6; tbl[17].up = 1'b0;
    tbl[21].sel = 8'hFE; tbl[21].up = 1'b0;
    tbl[25].sel = 8'hE6; tbl[25].up = 1'b0;

    periods = {8'd0, 8'd3, 8'd2, 8'd1};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sel", 32'(sel), 32'h0000_00FF);
    chk("reset_up",  32'(up),  32'h0000_0001);
    chk("reset_run", 32'(run), 32'h0000_0000);
    rst = 1'b0;

    for (int k = 0; k < 26; k++) begin
      start = tbl[k].start;
      mov   = tbl[k].mov;
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("tbl%0d_sel", k), 32'(sel), 32'(tbl[k].sel));
      chk($sformatf("tbl%0d_up", k),  32'(up),  32'(tbl[k].up));
      chk($sformatf("tbl%0d_run", k), 32'(run), 32'(tbl[k].run));
    end

    // forced shift mid-period, then lane2 natural shift three ticks later
    repeat (5) step_chk("pre_force");
    mov = 1'b0;
    step_chk("force");
    chk("force_all", 32'(sel), 32'h0000_00E6);
    step_chk("force_after");
    chk("force_one_clk", 32'(sel), 32'h0000_00FF);
    mov = 1'b1;
    repeat (9) step_chk("post_force");
    chk("lane2_3ticks", 32'(sel), 32'h0000_00EE);

    // forced and natural shift in the same clock
    align_tick("coinc");
    mov = 1'b0;
    step_chk("coinc");
    chk("coinc_sel", 32'(sel), 32'h0000_00E6);
    chk("coinc_up",  32'(up),  32'h0000_0000);
    step_chk("coinc_after");
    chk("coinc_single", 32'(sel), 32'h0000_00FF);
    mov = 1'b1;

    // pause request colliding with a tick, edge ignored while paused
    align_tick("pause");
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) mov = 1'b0;
      step_chk("pause");
      chk("pause_sel", 32'(sel), 32'h0000_00FF);
      chk("pause_up",  32'(up),  32'h0000_0001);
      chk("pause_run", 32'(run), 32'h0000_0000);
    end
    start = 1'b1;
    step_chk("unpause0");
    chk("unpause0_up", 32'(up), 32'h0000_0001);
    step_chk("unpause1");
    chk("unpause_tick", 32'(up), 32'h0000_0000);
    chk("unpause_lane0", 32'(sel[1:0]), 32'h0000_0002);
    mov = 1'b1;

    // randomized stimulus against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 29) == 0) begin
        for (int i = 0; i < NL; i++) periods[i*CW +: CW] = 8'($urandom_range(0, 5));
      end
      start = ($urandom_range(0, 9) != 0);
      mov   = ($urandom_range(0, 3) != 0);
      step_chk("rand");
    end

    // asynchronous reset while lane0 is shifting
    start = 1'b1;
    mov = 1'b1;
    periods = {8'd0, 8'd3, 8'd2, 8'd1};
    align_tick("rst_mid");
    step_chk("rst_mid");
    chk("rst_mid_lane0", 32'(sel[1:0]), 32'h0000_0002);
    #2;
    rst = 1'b1;
    #1;
    chk("async_sel", 32'(sel), 32'h0000_00FF);
    chk("async_up",  32'(up),  32'h0000_0001);
    chk("async_run", 32'(run), 32'h0000_0000);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step_chk("rerun1");
    chk("rerun1_sel", 32'(sel), 32'h0000_00FF);
    step_chk("rerun2");
    chk("rerun_load", 32'(sel), 32'h0000_0000);
    step_chk("rerun3");
    chk("rerun_run", 32'(run), 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
